// File: rtl/tt_link_pkg.sv
// Shared definitions for the host serial link: transmitter FSM states,
// default baud divider and line levels for the frame delimiters.
package tt_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned TT_LINK_CLK_DIV = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tt_uart_tx_if.sv
// Byte-write channel into the UART transmitter queue, plus the queue
// occupancy reported back to the writer.
interface tt_uart_tx_if
    import tt_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    logic [7:0]              wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(DEPTH):0]  level;

    modport master (output wr_data, output wr_valid, input wr_ready, input level);
    modport slave  (input wr_data, input wr_valid, output wr_ready, output level);
endinterface

// File: rtl/tt_sync_fifo.sv
// Single-clock show-ahead FIFO; rdata always presents the head entry.
// Writes into a full FIFO are dropped even when a pop happens on the same edge.
module tt_sync_fifo
    import tt_link_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Occupancy is tracked on its own so full/empty never depend on pointer compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tt_uart_tx.sv
// Buffered UART transmitter: queued bytes leave as 8N1 frames at clk/CLK_DIV baud.
// Define TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module tt_uart_tx
    import tt_link_pkg::*;
#(
    parameter int unsigned CLK_DIV = TT_LINK_CLK_DIV,
    parameter int unsigned DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    tt_uart_tx_if.slave   wr_if,
    output logic          tx,
    output logic          busy
);
    localparam int unsigned LW         = $clog2(DEPTH) + 1;
    localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_busy;
    logic          w_tick;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [LW-1:0] w_level;
`ifdef TX_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    tt_sync_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_if.wr_valid),
        .pop   (w_pop),
        .wdata (wr_if.wr_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign wr_if.wr_ready = !w_full;
    assign wr_if.level    = w_level;
    assign w_tick         = (r_cnt == '0);
    assign tx             = r_tx;
    assign busy           = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
`ifdef TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (r_state != IDLE) w_cnt_nxt = w_tick ? DIV_RELOAD : r_cnt - 16'd1;

        case (r_state)
            IDLE: begin
                w_tx_nxt  = STOP_BIT;
                w_cnt_nxt = '0;
            end
            START: if (w_tick) begin
                w_state_nxt = DATA;
                w_idx_nxt   = '0;
                w_tx_nxt    = r_shift[0];
            end
            DATA: if (w_tick) begin
                if (r_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                    w_state_nxt = PARITY;
                    w_tx_nxt    = r_par;
`else
                    w_state_nxt = STOP;
                    w_tx_nxt    = STOP_BIT;
`endif
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_tx_nxt    = r_shift[1];
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (w_tick) begin
                w_state_nxt = STOP;
                w_tx_nxt    = STOP_BIT;
            end
`endif
            STOP: if (w_tick) begin
                w_state_nxt = IDLE;
                w_tx_nxt    = STOP_BIT;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = STOP_BIT;
                w_cnt_nxt   = '0;
            end
        endcase

        // Frame launch shared by IDLE and the end of STOP (back-to-back frames).
        if (en && !w_empty && (r_state == IDLE || (r_state == STOP && w_tick))) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = START_BIT;
            w_cnt_nxt   = DIV_RELOAD;
            w_shift_nxt = w_head;
            w_idx_nxt   = '0;
`ifdef TX_PARITY_EN
            w_par_nxt   = ^w_head;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= STOP_BIT;
            r_busy  <= 1'b0;
`ifdef TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != IDLE);
`ifdef TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

endmodule
